decode: RTL
===========

DECODE -- requirements
Module: decode

Interface
REQ-001 The block SHALL have parameter ZERO_REG, default 1, meaning register r0 reads as 0 and ignores writes when 1.
REQ-002 The block SHALL have port clock  input  1  rising-edge clock for all state.
REQ-003 The block SHALL have port reset  input  1  synchronous, active-high reset, sampled on rising clock.
REQ-004 The block SHALL have port IF_ID  input  64  fetch-to-decode bus: [63] valid, [62:32] reserved, [31:0] instruction.
REQ-005 The block SHALL have port flush  input  1  discards the instruction currently on IF_ID.
REQ-006 The block SHALL have port wb_en  input  1  register-file write enable from writeback.
REQ-007 The block SHALL have port wb_addr  input  5  register-file write address.
REQ-008 The block SHALL have port wb_data  input  64  register-file write data.
REQ-009 The block SHALL have port stall  output  1  combinational; fetch holds IF_ID while high.
REQ-010 The block SHALL have port ID_EX  output  181  registered decode-to-execute bus consumed by execute.

Function
REQ-011 The block SHALL decode the instruction as: [31:28] alu_op, [27:23] rd, [22:18] rs1, [17:13] rs2, [12] use_imm, [11:0] imm12.
REQ-012 The block SHALL lay out ID_EX as: [180] valid, [179:116] opA, [115:52] opB, [51:20] imm (imm12 sign-extended to 32), [19:15] rd, [14:11] alu_op, [10] reg_write, [9] use_imm, [8:0] driven 0.
REQ-013 The block SHALL set reg_write=1 for every alu_op except 4'hF, which is a no-write op.
REQ-014 The block SHALL hold a 32x64 register file, written on the rising clock when wb_en=1; writes to r0 are dropped when ZERO_REG=1.
REQ-015 The block SHALL read opA=reg[rs1] and opB=reg[rs2], substituting wb_data when wb_en=1 and wb_addr matches the source (write-through bypass; r0 excluded when ZERO_REG=1).
REQ-016 The block SHALL keep a 32-bit pending scoreboard: bit rd is set when an instruction with reg_write=1 and rd!=0 issues; bit wb_addr is cleared when wb_en=1.
REQ-017 If the same register is set and cleared in the same cycle, set SHALL win.
REQ-018 Source rs1 SHALL be hazardous when pending[rs1]=1 and not bypassed by REQ-015; rs2 SHALL be checked the same way only when use_imm=0.
REQ-019 stall SHALL equal IF_ID[63] AND NOT flush AND (rs1 hazardous OR rs2 hazardous).
REQ-020 An instruction SHALL issue on a clock edge when IF_ID[63]=1, flush=0 and stall=0: ID_EX loads all decoded fields with valid=1, latency 1 cycle.
REQ-021 When the instruction does not issue (invalid, flushed or stalled), ID_EX SHALL load all-zero (bubble) and the scoreboard SHALL not be set.
REQ-022 flush SHALL take priority over stall; a flushed instruction never issues and never sets pending.
REQ-023 Pending bits of already-issued instructions SHALL be unaffected by flush.
REQ-024 Back-to-back independent instructions SHALL issue on consecutive cycles with no bubble.

Reset
REQ-025 While reset=1 at a clock edge, ID_EX, all register-file entries and all pending bits SHALL be cleared to 0.
REQ-026 While reset=1, the register-file write port and issue SHALL be suppressed; stall SHALL be 0 on the cycle after reset deasserts (scoreboard clear).
REQ-027 Reset asserted mid-stall SHALL drop the stalled instruction, with no issue on a later cycle unless it is re-presented.

Verification
REQ-028 A reset test SHALL hold reset for 2 cycles with IF_ID=64'hFFFFFFFFFFFFFFFF, then check ID_EX=0, stall=0 and reg[5]=0 in readback.
REQ-029 A write/read test SHALL write wb r3=64'h1234 and then issue rs1=3, rs2=0, use_imm=1, imm12=12'hFFF, requiring ID_EX opA=64'h1234, opB=0, imm=32'hFFFFFFFF, valid=1 one cycle later.
REQ-030 A hazard test SHALL issue rd=7 followed by rs1=7, requiring stall=1 and bubble ID_EX until wb_en with wb_addr=7 and wb_data=64'hAB; in that same cycle stall=0, and the next ID_EX opA=64'hAB.
REQ-031 A flush test SHALL hold a stalled instruction with flush=1, requiring stall=0, ID_EX valid=0 and pending unchanged.
REQ-032 A same-cycle test SHALL issue rd=9 while wb_en writes 9, requiring pending[9]=1 afterwards (observed as stall for a following rs1=9).
REQ-033 An r0 test SHALL write wb r0=64'hFF and then issue rs1=0 with rd=0, requiring opA=0 and no stall for a following rs1=0.

Source files
------------

// File: rtl/decode.sv
// Decode stage: field extraction, 32x64 register file with write-through
// bypass, pending-write scoreboard with stall, and the ID_EX pipeline register.
module decode #(
  parameter bit ZERO_REG = 1'b1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [63:0]  IF_ID,
  input  logic         flush,
  input  logic         wb_en,
  input  logic [4:0]   wb_addr,
  input  logic [63:0]  wb_data,
  output logic         stall,
  output logic [180:0] ID_EX
);

  logic [63:0] rf [32];
  logic [31:0] pending;

  logic        in_valid;
  logic [3:0]  alu_op;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        use_imm;
  logic [11:0] imm12;
  logic        reg_write;
  logic        unused_rsvd;

  assign in_valid    = IF_ID[63];
  assign alu_op      = IF_ID[31:28];
  assign rd          = IF_ID[27:23];
  assign rs1         = IF_ID[22:18];
  assign rs2         = IF_ID[17:13];
  assign use_imm     = IF_ID[12];
  assign imm12       = IF_ID[11:0];
  assign reg_write   = (alu_op != 4'hF);
  assign unused_rsvd = ^IF_ID[62:32];

  logic zr1;
  logic zr2;
  logic byp1;
  logic byp2;
  logic haz1;
  logic haz2;
  logic issue;
  logic wb_we;
  logic [63:0] op_a;
  logic [63:0] op_b;

  assign zr1  = ZERO_REG && (rs1 == 5'd0);
  assign zr2  = ZERO_REG && (rs2 == 5'd0);
  assign byp1 = wb_en && (wb_addr == rs1) && !zr1;
  assign byp2 = wb_en && (wb_addr == rs2) && !zr2;

  always_comb begin
    op_a = rf[rs1];
    if (zr1)       op_a = '0;
    else if (byp1) op_a = wb_data;
  end

  always_comb begin
    op_b = rf[rs2];
    if (zr2)       op_b = '0;
    else if (byp2) op_b = wb_data;
  end

  // A bypassed source is satisfied this cycle even if still marked pending.
  assign haz1  = pending[rs1] && !byp1;
  assign haz2  = !use_imm && pending[rs2] && !byp2;
  assign stall = in_valid && !flush && (haz1 || haz2);
  assign issue = in_valid && !flush && !stall && !reset;
  assign wb_we = wb_en && !(ZERO_REG && (wb_addr == 5'd0));

  logic [31:0] set_vec;
  logic [31:0] clr_vec;

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (issue && reg_write && (rd != 5'd0)) set_vec[rd] = 1'b1;
    if (wb_en) clr_vec[wb_addr] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (wb_we) begin
      rf[wb_addr] <= wb_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) pending <= '0;
    else       pending <= (pending & ~clr_vec) | set_vec;
  end

  always_ff @(posedge clock) begin
    if (reset || !issue) begin
      ID_EX <= '0;
    end else begin
      ID_EX <= {1'b1, op_a, op_b,
                {{20{imm12[11]}}, imm12},
                rd, alu_op, reg_write, use_imm,
                9'd0};
    end
  end

endmodule
